// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RISC-V-lite instruction decode stage.
// Decodes ir_in, reads an internal 2R1W register file and loads the ID/EX
// pipeline register under a valid/ready handshake. Inserts one bubble on a
// load-use hazard against its own ID/EX contents and supports flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid is high and ready is
// low, and ready never depends on anything the consumer will do later.
//
// Build option DEC_BYPASS_EN: when defined, register reads are write-through
// (a same-cycle write-back to the read register supplies the operand). When
// undefined, that same-cycle match stalls ID for one cycle instead.
module decode_pipe_stage #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int CW_W     = 15,
    parameter int LOAD_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   npc_in,
    input  logic [CW_W-1:0]   cw_in,
    input  logic [3:0]        aluop_in,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   r1,
    output logic [XLEN-1:0]   r2,
    output logic [XLEN-1:0]   imm_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   npc_out,
    output logic [CW_W-3:0]   cw_exe,
    output logic [3:0]        aluop_exe,
    output logic [RA_W-1:0]   rd_out
);

    localparam int NREG = 2 ** RA_W;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Register file (x0 is never written, so it stays zero after reset)
    logic [XLEN-1:0] rf_q [NREG];

    // ID/EX pipeline register
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   r1_q, r1_d;
    logic [XLEN-1:0]   r2_q, r2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [CW_W-3:0]   cw_exe_q, cw_exe_d;
    logic [3:0]        aluop_q, aluop_d;
    logic [RA_W-1:0]   rd_q, rd_d;

    // Decode / hazard nets
    logic [RA_W-1:0]   rs1, rs2, rd;
    logic              use1, use2;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   op1, op2;
    logic              wb_we;
    logic              load_haz, wb_haz, haz, adv;

    // Register fields and operand-use flags from the instruction and control word
    always_comb begin
        rs1   = ir_in[15 +: RA_W];
        rs2   = ir_in[20 +: RA_W];
        rd    = ir_in[7 +: RA_W];
        use1  = cw_in[CW_W-1];
        use2  = cw_in[CW_W-2];
        wb_we = wb_en && (wb_addr != '0);
    end

    // Immediate selection by opcode, then sign extension to XLEN
    always_comb begin
        imm32 = '0;
        unique case (ir_in[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{ir_in[31]}}, ir_in[31:20]};
            OP_STORE:
                imm32 = {{20{ir_in[31]}}, ir_in[31:25], ir_in[11:7]};
            OP_BRANCH:
                imm32 = {{19{ir_in[31]}}, ir_in[31], ir_in[7], ir_in[30:25], ir_in[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {ir_in[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{ir_in[31]}}, ir_in[31], ir_in[19:12], ir_in[20], ir_in[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_ext        = {XLEN{imm32[31]}};
        imm_ext[31:0]  = imm32;
    end

    // Operand read: unused operands and x0 read as zero
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (use1 && rs1 != '0) begin
            op1 = rf_q[rs1];
`ifdef DEC_BYPASS_EN
            if (wb_we && wb_addr == rs1) op1 = wb_data;
`endif
        end
        if (use2 && rs2 != '0) begin
            op2 = rf_q[rs2];
`ifdef DEC_BYPASS_EN
            if (wb_we && wb_addr == rs2) op2 = wb_data;
`endif
        end
    end

    // Hazard detection and handshake
    always_comb begin
        load_haz = out_valid_q && cw_exe_q[LOAD_BIT] && (rd_q != '0) && in_valid &&
                   ((use1 && rs1 == rd_q) || (use2 && rs2 == rd_q));
`ifdef DEC_BYPASS_EN
        wb_haz   = 1'b0;
`else
        // Without write-through, a same-cycle write to a read register must wait a cycle
        wb_haz   = in_valid && wb_we &&
                   ((use1 && rs1 == wb_addr) || (use2 && rs2 == wb_addr));
`endif
        haz      = load_haz || wb_haz;
        adv      = !out_valid_q || out_ready;
        in_ready = rst && adv && !haz && !flush;
    end

    // ID/EX next state: load, bubble, flush or hold
    always_comb begin
        out_valid_d = out_valid_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        cw_exe_d    = cw_exe_q;
        aluop_d     = aluop_q;
        rd_d        = rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
            cw_exe_d    = '0;
            aluop_d     = '0;
            rd_d        = '0;
        end else if (adv) begin
            if (in_valid && !haz) begin
                out_valid_d = 1'b1;
                r1_d        = op1;
                r2_d        = op2;
                imm_d       = imm_ext;
                pc_d        = pc_in;
                npc_d       = npc_in;
                cw_exe_d    = cw_in[CW_W-3:0];
                aluop_d     = aluop_in;
                rd_d        = rd;
            end else begin
                out_valid_d = 1'b0;
                cw_exe_d    = '0;
                aluop_d     = '0;
                rd_d        = '0;
            end
        end
    end

    // ID/EX register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            npc_q       <= '0;
            cw_exe_q    <= '0;
            aluop_q     <= '0;
            rd_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            cw_exe_q    <= cw_exe_d;
            aluop_q     <= aluop_d;
            rd_q        <= rd_d;
        end
    end

    // Register file write port; flush does not block write-back
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = out_valid_q;
    assign r1        = r1_q;
    assign r2        = r2_q;
    assign imm_out   = imm_q;
    assign pc_out    = pc_q;
    assign npc_out   = npc_q;
    assign cw_exe    = cw_exe_q;
    assign aluop_exe = aluop_q;
    assign rd_out    = rd_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Testbench for decode_pipe_stage: decode table, hand-written hazard/stall/flush
// sequences and randomized traffic against a behavioural model.
module tb_decode_pipe_stage;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int CW_W     = 15;
  localparam int LOAD_BIT = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready;
  logic [31:0]       ir_in;
  logic [XLEN-1:0]   pc_in, npc_in;
  logic [CW_W-1:0]   cw_in;
  logic [3:0]        aluop_in;
  logic              wb_en;
  logic [RA_W-1:0]   wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   r1, r2, imm_out, pc_out, npc_out;
  logic [CW_W-3:0]   cw_exe;
  logic [3:0]        aluop_exe;
  logic [RA_W-1:0]   rd_out;

  decode_pipe_stage #(.XLEN(XLEN), .RA_W(RA_W), .CW_W(CW_W), .LOAD_BIT(LOAD_BIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ir_in(ir_in), .pc_in(pc_in), .npc_in(npc_in), .cw_in(cw_in), .aluop_in(aluop_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .r1(r1), .r2(r2), .imm_out(imm_out),
    .pc_out(pc_out), .npc_out(npc_out), .cw_exe(cw_exe), .aluop_exe(aluop_exe), .rd_out(rd_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic            m_valid;
  logic [XLEN-1:0] m_r1, m_r2, m_imm, m_pc, m_npc;
  logic [CW_W-3:0] m_cw;
  logic [3:0]      m_alu;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_rf [32];
  logic            seen_ready;

  // Immediate value computed arithmetically from the instruction fields
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] ir);
    longint v;
    v = 0;
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        v = longint'(ir[30:20]) - (ir[31] ? 2048 : 0);
      7'b0100011:
        v = longint'(ir[30:25]) * 32 + longint'(ir[11:7]) - (ir[31] ? 2048 : 0);
      7'b1100011:
        v = longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2
            - (ir[31] ? 4096 : 0);
      7'b0110111, 7'b0010111:
        v = longint'(ir[30:12]) * 4096 - (ir[31] ? 64'sd2147483648 : 64'sd0);
      7'b1101111:
        v = longint'(ir[19:12]) * 4096 + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2
            - (ir[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] ref_read(input logic used, input logic [4:0] rs);
    logic [XLEN-1:0] val;
    val = '0;
    if (used && rs != 0) begin
      val = m_rf[rs];
`ifdef DEC_BYPASS_EN
      if (wb_en && wb_addr != 0 && wb_addr == rs) val = wb_data;
`endif
    end
    return val;
  endfunction

  // One clock: check in_ready, advance the model, check the registered outputs
  task automatic do_cycle();
    logic [4:0] rs1, rs2;
    logic u1, u2, lh, wh, haz, adv, exp_rdy;
    logic [XLEN-1:0] o1, o2;
    #1;
    rs1 = ir_in[19:15];
    rs2 = ir_in[24:20];
    u1  = cw_in[CW_W-1];
    u2  = cw_in[CW_W-2];
    lh  = m_valid && m_cw[LOAD_BIT] && m_rd != 0 && in_valid &&
          ((u1 && rs1 == m_rd) || (u2 && rs2 == m_rd));
`ifdef DEC_BYPASS_EN
    wh  = 1'b0;
`else
    wh  = in_valid && wb_en && wb_addr != 0 && ((u1 && rs1 == wb_addr) || (u2 && rs2 == wb_addr));
`endif
    haz = lh || wh;
    adv = !m_valid || out_ready;
    exp_rdy = rst && adv && !haz && !flush;
    seen_ready = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    o1 = ref_read(u1, rs1);
    o2 = ref_read(u2, rs2);
    if (!rst) begin
      m_valid = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0; m_npc = 0;
      m_cw = 0; m_alu = 0; m_rd = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      if (flush) begin
        m_valid = 0; m_cw = 0; m_alu = 0; m_rd = 0;
      end else if (adv) begin
        if (in_valid && !haz) begin
          m_valid = 1; m_r1 = o1; m_r2 = o2; m_imm = ref_imm(ir_in);
          m_pc = pc_in; m_npc = npc_in; m_cw = cw_in[CW_W-3:0]; m_alu = aluop_in;
          m_rd = ir_in[11:7];
        end else begin
          m_valid = 0; m_cw = 0; m_alu = 0; m_rd = 0;
        end
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("cw_exe", cw_exe, m_cw);
    chk("aluop_exe", aluop_exe, m_alu);
    chk("rd_out", rd_out, m_rd);
    if (m_valid) begin
      chk("r1", r1, m_r1);
      chk("r2", r2, m_r2);
      chk("imm_out", imm_out, m_imm);
      chk("pc_out", pc_out, m_pc);
      chk("npc_out", npc_out, m_npc);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_idle();
    in_valid = 0; ir_in = 0; cw_in = 0; aluop_in = 0;
    pc_in = 0; npc_in = 4; wb_en = 0; wb_addr = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [CW_W-1:0] cw);
    in_valid = 1; ir_in = ir; cw_in = cw;
    aluop_in = 4'($urandom_range(0, 15));
    pc_in = $urandom & 32'hFFFF_FFFC; npc_in = pc_in + 4;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0]     ir;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
  } vec_t;

  vec_t vecs [11];

  logic [6:0] opcs [9];

  initial begin
    vecs[0]  = '{32'hFFB00093, 32'hFFFFFFFB, 5'd1};   // addi x1,x0,-5
    vecs[1]  = '{32'h0081A103, 32'h00000008, 5'd2};   // lw x2,8(x3)
    vecs[2]  = '{32'hFE532E23, 32'hFFFFFFFC, 5'd28};  // sw x5,-4(x6)
    vecs[3]  = '{32'hFE000CE3, 32'hFFFFFFF8, 5'd25};  // beq -8
    vecs[4]  = '{32'h123453B7, 32'h12345000, 5'd7};   // lui x7
    vecs[5]  = '{32'hFFFFF417, 32'hFFFFF000, 5'd8};   // auipc x8
    vecs[6]  = '{32'h001000EF, 32'h00000800, 5'd1};   // jal x1,+2048
    vecs[7]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 5'd0};   // jal x0,-2
    vecs[8]  = '{32'h7FF100E7, 32'h000007FF, 5'd1};   // jalr x1,2047(x2)
    vecs[9]  = '{32'h00208033, 32'h00000000, 5'd0};   // add (no immediate)
    vecs[10] = '{32'hFFFFFFFF, 32'h00000000, 5'd31};  // unknown opcode
    opcs = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    set_idle();

    // Reset: two cycles with in_valid high
    rst = 0;
    issue(32'hFFB00093, 15'h0000);
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      chk("rst_in_ready", seen_ready, 1'b0);
    end
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_r1", r1, 32'h0);
    chk("rst_r2", r2, 32'h0);
    chk("rst_imm", imm_out, 32'h0);
    rst = 1;

    // addi x1,x0,-5 with rs1 used
    issue(32'hFFB00093, 15'h4000);
    do_cycle();
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", imm_out, 32'hFFFFFFFB);
    chk("addi_rd", rd_out, 5'd1);
    chk("addi_r1", r1, 32'h0);

    // Decode table: no operands used, never a load
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].ir, {2'b00, 13'(i * 6 + 2)});
      do_cycle();
      chk("tab_valid", out_valid, 1'b1);
      chk("tab_imm", imm_out, vecs[i].imm);
      chk("tab_rd", rd_out, vecs[i].rd);
    end

    // Load-use: lw x5,0(x1) then add x6,x5,x5
    issue(32'h0000A283, 15'h4001);
    do_cycle();
    chk("lu_load_valid", out_valid, 1'b1);
    issue(32'h00528333, 15'h6010);
    do_cycle();
    chk("lu_stall_ready", seen_ready, 1'b0);
    chk("lu_bubble", out_valid, 1'b0);
    do_cycle();
    chk("lu_accept_ready", seen_ready, 1'b1);
    chk("lu_add_valid", out_valid, 1'b1);
    chk("lu_add_rd", rd_out, 5'd6);

    // Same-cycle write-back to x3 while ID reads x3 (addi x4,x3,0)
    issue(32'h00018213, 15'h4000);
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    do_cycle();
`ifdef DEC_BYPASS_EN
    chk("wb_ready", seen_ready, 1'b1);
    chk("wb_valid", out_valid, 1'b1);
    chk("wb_r1", r1, 32'hDEADBEEF);
    wb_en = 0;
`else
    chk("wb_ready", seen_ready, 1'b0);
    chk("wb_bubble", out_valid, 1'b0);
    wb_en = 0;
    do_cycle();
    chk("wb_ready2", seen_ready, 1'b1);
    chk("wb_valid", out_valid, 1'b1);
    chk("wb_r1", r1, 32'hDEADBEEF);
`endif

    // Back-pressure with flush in the second stalled cycle
    issue(32'hFFB00093, 15'h4000);
    do_cycle();
    issue(32'h0081A103, 15'h4000);
    out_ready = 0;
    do_cycle();
    chk("bp_ready", seen_ready, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_imm", imm_out, 32'hFFFFFFFB);
    chk("bp_rd", rd_out, 5'd1);
    flush = 1;
    do_cycle();
    chk("fl_ready", seen_ready, 1'b0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_rd", rd_out, 5'd0);
    flush = 0;
    do_cycle();
    chk("fl_after_valid", out_valid, 1'b1);
    out_ready = 1;

    // Write to x0 is ignored, then read x0
    set_idle();
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
    do_cycle();
    wb_en = 0;
    issue(32'h00000493, 15'h4000);
    do_cycle();
    chk("x0_valid", out_valid, 1'b1);
    chk("x0_r1", r1, 32'h0);

    // Randomized traffic with small register ranges to provoke collisions
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ir;
      rst = (c == 300) ? 1'b0 : 1'b1;
      ir = $urandom;
      ir[6:0]   = opcs[$urandom_range(0, 8)];
      ir[11:7]  = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
      issue(ir, 15'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
